md_unit: RTL

- Multi-cycle multiply/divide unit with HI/LO registers for the 5-stage MIPS core; sits in the E stage beside the ALU.
- Successor to the current single-issue datapath: parametrised operand width and per-operation latency, plus a busy handshake and a cancel input.
- The hazard unit stalls MD-dependent instructions in D using start and busy.

---
 rtl/md_pkg.sv | 23 ++
 rtl/md_calc.sv | 85 ++++++++
 rtl/md_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op/state encodings and counter sizing for the multiply/divide unit
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // A one-cycle latency still needs a one-bit counter to hold zero.
    function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
        int mx;
        mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return (mx <= 1) ? 1 : $clog2(mx);
    endfunction

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational HI/LO result for multiply and divide, including divide-by-zero and overflow
module md_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0]       a_sx;
    logic [2*WIDTH-1:0]       b_sx;
    logic [2*WIDTH-1:0]       a_zx;
    logic [2*WIDTH-1:0]       b_zx;
    logic [2*WIDTH-1:0]       prod_s;
    logic [2*WIDTH-1:0]       prod_u;
    logic signed [WIDTH-1:0]  quot_s;
    logic signed [WIDTH-1:0]  rem_s;
    logic [WIDTH-1:0]         quot_u;
    logic [WIDTH-1:0]         rem_u;
    logic                     div_zero;
    logic                     div_ovf;

    // Modular product of sign-extended operands equals the signed product.
    assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
    assign a_zx   = {{WIDTH{1'b0}}, a};
    assign b_zx   = {{WIDTH{1'b0}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    assign quot_s = $signed(a) / $signed(b);
    assign rem_s  = $signed(a) % $signed(b);
    assign quot_u = a / b;
    assign rem_u  = a % b;

    assign div_zero = (b == '0);
    assign div_ovf  = (a == MOST_NEG) && (b == '1);

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op)
            MD_MULT: begin
                res_hi = prod_s[2*WIDTH-1:WIDTH];
                res_lo = prod_s[WIDTH-1:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[2*WIDTH-1:WIDTH];
                res_lo = prod_u[WIDTH-1:0];
            end
            MD_DIV: begin
                if (div_zero) begin
                    res_hi = a;
                    res_lo = '1;
                end else if (div_ovf) begin
                    res_hi = '0;
                    res_lo = a;
                end else begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            MD_DIVU: begin
                if (div_zero) begin
                    res_hi = a;
                    res_lo = '1;
                end else begin
                    res_hi = rem_u;
                    res_lo = quot_u;
                end
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO registers and busy/done/cancel handshake
// Optional MD_EARLY_OUT_EN: zero-operand multiplies and divide-by-zero commit on the accept edge.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] calc_hi;
    logic [WIDTH-1:0] calc_lo;
    logic             accept;
    logic             early_out;

    md_calc #(.WIDTH(WIDTH)) u_calc (
        .op     (op),
        .a      (a),
        .b      (b),
        .res_hi (calc_hi),
        .res_lo (calc_lo)
    );

    assign accept = start && !cancel && (state_q == IDLE);

`ifdef MD_EARLY_OUT_EN
    always_comb begin
        early_out = 1'b0;
        case (op)
            MD_MULT, MD_MULTU: early_out = (a == '0) || (b == '0);
            MD_DIV, MD_DIVU:   early_out = (b == '0);
            default:           early_out = 1'b0;
        endcase
    end
`else
    assign early_out = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            pend_hi_d = calc_hi;
                            pend_lo_d = calc_lo;
                            if (early_out) begin
                                hi_d   = calc_hi;
                                lo_d   = calc_lo;
                                done_d = 1'b1;
                            end else begin
                                state_d = RUN;
                                cnt_d   = (op == MD_MULT || op == MD_MULTU) ? MULT_LOAD : DIV_LOAD;
                            end
                        end
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Cancel wins even on the commit edge.
                if (cancel) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
